// File: rtl/router_op_lut_event_pacer.sv
`default_nettype none
// ============================================================================
//  Module   : router_op_lut_event_pacer
//  Brief    : Per-channel event pacer. It takes single-cycle event pulses,
//             queues them in a saturating pending counter and re-emits them
//             as one-cycle update pulses. Pulses on one channel are spaced at
//             least MIN_UPDATE_INTERVAL clocks apart. Dropped events raise a
//             sticky overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module router_op_lut_event_pacer #(
    parameter int NUM_EVENTS          = 10,
    parameter int MIN_UPDATE_INTERVAL = 8,
    parameter int PEND_WIDTH          = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] events_in,
    input  logic                  overflow_clr,
    output logic [NUM_EVENTS-1:0] updates_out,
    output logic [NUM_EVENTS-1:0] overflow,
    output logic                  idle
);

    // When the interval is 1 the gap loads 0, so a channel may fire every clock
    localparam logic [7:0]            c_gap_load = 8'(MIN_UPDATE_INTERVAL - 1);
    localparam logic [PEND_WIDTH-1:0] c_pend_max = '1;
    localparam logic [PEND_WIDTH-1:0] c_pend_one = {{(PEND_WIDTH-1){1'b0}}, 1'b1};

    // Per-channel "will be busy after this edge" flags feed the registered idle
    logic [NUM_EVENTS-1:0] w_busy_nxt;
    logic                  r_idle;

    generate
        for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_ch
            logic [PEND_WIDTH-1:0] r_pend;
            logic [PEND_WIDTH-1:0] w_pend_nxt;
            logic [7:0]            r_gap;
            logic [7:0]            w_gap_nxt;
            logic                  r_out;
            logic                  w_out_nxt;
            logic                  r_ovf;
            logic                  w_ovf_nxt;
            logic                  w_eligible;
            logic                  w_drop;

            // Next-state for one channel: fire when the gap has expired and work exists
            always_comb begin
                w_pend_nxt = r_pend;
                w_gap_nxt  = r_gap;
                w_out_nxt  = 1'b0;
                w_drop     = 1'b0;
                w_eligible = (r_gap == 8'd0) && ((r_pend != '0) || events_in[gi]);

                if (w_eligible) begin
                    w_out_nxt = 1'b1;
                    w_gap_nxt = c_gap_load;
                    // An arriving event replaces the one consumed by this pulse
                    if (!events_in[gi]) begin
                        w_pend_nxt = r_pend - c_pend_one;
                    end
                end else begin
                    if (r_gap != 8'd0) begin
                        w_gap_nxt = r_gap - 8'd1;
                    end
                    if (events_in[gi]) begin
                        if (r_pend == c_pend_max) begin
                            w_drop = 1'b1;
                        end else begin
                            w_pend_nxt = r_pend + c_pend_one;
                        end
                    end
                end

                // A fresh drop wins over a simultaneous clear
                w_ovf_nxt = w_drop | (r_ovf & ~overflow_clr);
            end

            // Channel state registers
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pend <= '0;
                    r_gap  <= 8'd0;
                    r_out  <= 1'b0;
                    r_ovf  <= 1'b0;
                end else begin
                    r_pend <= w_pend_nxt;
                    r_gap  <= w_gap_nxt;
                    r_out  <= w_out_nxt;
                    r_ovf  <= w_ovf_nxt;
                end
            end

            assign updates_out[gi] = r_out;
            assign overflow[gi]    = r_ovf;
            assign w_busy_nxt[gi]  = (w_pend_nxt != '0) | w_out_nxt;
        end
    endgenerate

    // Idle reflects the register values that will exist after this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle <= 1'b1;
        end else begin
            r_idle <= ~(|w_busy_nxt);
        end
    end

    assign idle = r_idle;

endmodule
`default_nettype wire
